// File: rtl/neuron_mac_pipe.sv
// Pipelined multi-lane fixed-point MAC for a neuron: products -> accumulate -> round/saturate.
// Optional macro NEURON_MAC_RELU_EN clamps negative results to zero.
module neuron_mac_pipe #(
  parameter int WIDTH     = 32,
  parameter int FRAC      = 16,
  parameter int LANES     = 4,
  parameter int ACC_GUARD = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [LANES*WIDTH-1:0] input_data,
  input  logic [LANES*WIDTH-1:0] weight_data,
  input  logic [WIDTH-1:0]       bias,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   sat
);

  localparam int ACC_W  = 2*WIDTH + $clog2(LANES) + ACC_GUARD;
  localparam int RND_SH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [ACC_W-1:0] RND =
    (FRAC > 0) ? (ACC_W'(1) << RND_SH) : ACC_W'(0);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                   r_state;
  logic                     r_cnt;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [WIDTH-1:0]         r_out_data;
  logic                     r_sat;

  logic                     r_s1_vld;
  logic                     r_s1_first;
  logic signed [ACC_W-1:0]  r_s1_sum;
  logic signed [WIDTH-1:0]  r_s1_bias;
  logic signed [ACC_W-1:0]  r_acc;

  logic                     w_accept;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_bias_ext;
  logic signed [ACC_W-1:0]  w_rnd;
  logic signed [ACC_W-1:0]  w_shr;
  logic [WIDTH-1:0]         w_res;
  logic                     w_sat;

  assign w_accept  = in_valid & r_in_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sat       = r_sat;

  // Lane operands are widened to 2*WIDTH before multiplying so the full product is kept.
  always_comb begin
    logic signed [2*WIDTH-1:0] a;
    logic signed [2*WIDTH-1:0] b;
    logic signed [2*WIDTH-1:0] p;
    a     = '0;
    b     = '0;
    p     = '0;
    w_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      a     = (2*WIDTH)'($signed(input_data[i*WIDTH +: WIDTH]));
      b     = (2*WIDTH)'($signed(weight_data[i*WIDTH +: WIDTH]));
      p     = a * b;
      w_sum = w_sum + ACC_W'(p);
    end
  end

  assign w_bias_ext = ACC_W'(r_s1_bias) <<< FRAC;
  assign w_rnd      = r_acc + RND;
  assign w_shr      = w_rnd >>> FRAC;

  always_comb begin
    w_res = w_shr[WIDTH-1:0];
    w_sat = 1'b0;
    if (w_shr > SAT_MAX) begin
      w_res = {1'b0, {(WIDTH-1){1'b1}}};
      w_sat = 1'b1;
    end else if (w_shr < SAT_MIN) begin
      w_res = {1'b1, {(WIDTH-1){1'b0}}};
      w_sat = 1'b1;
    end
`ifdef NEURON_MAC_RELU_EN
    if (w_res[WIDTH-1]) begin
      w_res = '0;
      w_sat = 1'b0;
    end
`endif
  end

  // Stage 1: lane product sum with its first tag; bias captured only on first beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_bias  <= '0;
    end else if (clr) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_bias  <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_sum   <= w_sum;
        r_s1_first <= in_first;
        if (in_first) r_s1_bias <= bias;
      end
    end
  end

  // Stage 2: accumulator, reloaded from the bias on a first-tagged beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (r_s1_vld) begin
      r_acc <= r_s1_first ? (w_bias_ext + r_s1_sum) : (r_acc + r_s1_sum);
    end
  end

  // Control FSM; the DRAIN countdown lines up with the last beat leaving stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACC;
      r_cnt       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat       <= 1'b0;
    end else if (clr) begin
      r_state     <= ST_ACC;
      r_cnt       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat       <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          r_in_ready <= 1'b1;
          if (w_accept && in_last) begin
            r_state    <= ST_DRAIN;
            r_cnt      <= 1'b1;
            r_in_ready <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (r_cnt) begin
            r_cnt <= 1'b0;
          end else begin
            r_state     <= ST_HOLD;
            r_out_valid <= 1'b1;
            r_out_data  <= w_res;
            r_sat       <= w_sat;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state     <= ST_ACC;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_ACC;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_pipe.sv
// Scoreboard bench for neuron_mac_pipe: directed corner cases plus randomized vectors
// checked against an arbitrary-precision dot-product model.
module tb_neuron_mac_pipe;
  localparam int W = 32;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           clr = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_first = 1'b0;
  logic           in_last = 1'b0;
  logic [L*W-1:0] input_data = '0;
  logic [L*W-1:0] weight_data = '0;
  logic [W-1:0]   bias = '0;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           sat;

  logic rdy_force = 1'b0;
  logic rdy_rand  = 1'b0;
  bit   bp_rand   = 1'b0;
  assign out_ready = bp_rand ? rdy_rand : rdy_force;

  neuron_mac_pipe #(.WIDTH(32), .FRAC(16), .LANES(4), .ACC_GUARD(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .input_data(input_data), .weight_data(weight_data), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sat(sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    #2;
    rdy_rand = ($urandom_range(0, 3) != 0);
  end

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];
  logic signed [127:0] m_acc = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Exact real-number semantics: floor((acc + 0.5ulp) / 2^16), clip, optional ReLU.
  function automatic logic [32:0] model_out(input logic signed [127:0] acc);
    logic signed [127:0] r;
    logic [31:0] d;
    logic s;
    r = (acc + 128'sd32768) >>> 16;
    if (r > 128'sd2147483647) begin
      d = 32'h7FFFFFFF; s = 1'b1;
    end else if (r < -128'sd2147483648) begin
      d = 32'h80000000; s = 1'b1;
    end else begin
      d = r[31:0]; s = 1'b0;
    end
`ifdef NEURON_MAC_RELU_EN
    if (d[31]) begin
      d = '0; s = 1'b0;
    end
`endif
    return {s, d};
  endfunction

  function automatic logic signed [127:0] beat_sum(input logic [127:0] din, input logic [127:0] win);
    logic signed [127:0] s;
    logic signed [127:0] a;
    logic signed [127:0] b;
    s = '0;
    for (int i = 0; i < L; i++) begin
      a = $signed(din[i*32 +: 32]);
      b = $signed(win[i*32 +: 32]);
      s = s + a * b;
    end
    return s;
  endfunction

  function automatic logic [127:0] rep(input logic [31:0] x);
    return {4{x}};
  endfunction

  function automatic logic [31:0] small_val();
    int v;
    v = int'($urandom_range(0, 32'h7FFFF)) - 32'sh40000;
    return v;
  endfunction

  task automatic send_beat(input bit first, input bit last, input logic [127:0] din,
                           input logic [127:0] win, input logic [31:0] b, input bit push);
    int n;
    logic signed [127:0] bb;
    n = 0;
    in_valid = 1'b1; in_first = first; in_last = last;
    input_data = din; weight_data = win; bias = b;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    bb = $signed(b);
    if (first) m_acc = (bb <<< 16) + beat_sum(din, win);
    else       m_acc = m_acc + beat_sum(din, win);
    if (last && push) exp_q.push_back(model_out(m_acc));
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    #1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", out_valid, 1);
  endtask

  task automatic release_out();
    @(negedge clk);
    rdy_force = 1'b1;
    @(negedge clk);
    rdy_force = 1'b0;
    #1;
    chk("in_ready_after_hs", in_ready, 1);
    chk("out_valid_after_hs", out_valid, 0);
  endtask

  task automatic run_single(input logic [127:0] din, input logic [127:0] win,
                            input logic [31:0] b, input logic [31:0] exp_d, input logic exp_s);
    send_beat(1, 1, din, win, b, 1);
    wait_valid();
    chk("single_data", out_data, exp_d);
    chk("single_sat", sat, exp_s);
    release_out();
  endtask

  // Monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    logic [32:0] e;
    #1;
    if (rst_n && !clr && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %0h, no result expected", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", out_data, e[31:0]);
        chk("sb_sat", sat, e[32]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_d;
    int nb, n;
    bit mode, first;
    logic [127:0] din, win;
    logic [31:0] b;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sat", sat, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("in_ready_after_reset", in_ready, 1);
    @(negedge clk);

    // One-beat vector with first+last; latency and in_ready during drain.
    send_beat(1, 1, rep(32'h00010000), rep(32'h00020000), 32'h00008000, 1);
    #1;
    chk("lat_k_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 0);
    @(negedge clk); #1 chk("lat_k1_valid", out_valid, 0);
    @(negedge clk); #1 chk("lat_k2_valid", out_valid, 1);
    chk("one_beat_data", out_data, 32'h00088000);
    chk("one_beat_sat", sat, 0);
    release_out();

    // Three-beat vector, then HOLD with stray beats offered.
    send_beat(1, 0, rep(32'h00010000), rep(32'h00010000), 32'h0, 1);
    send_beat(0, 0, rep(32'h00010000), rep(32'h00010000), 32'h0, 1);
    send_beat(0, 1, rep(32'h00010000), rep(32'h00010000), 32'h0, 1);
    #1 chk("three_beat_in_ready", in_ready, 0);
    wait_valid();
    chk("three_beat_data", out_data, 32'h000C0000);
    hold_d = out_data;
    @(negedge clk);
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
    input_data = rep(32'h00050000); weight_data = rep(32'h00050000); bias = 32'h00010000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("hold_data_stable", out_data, hold_d);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    release_out();
    repeat (3) @(negedge clk);
    #1 chk("no_stray_result", out_valid, 0);

    // Rounding at half-ulp boundaries.
    run_single({96'h0, 32'h00008000}, {96'h0, 32'h00000001}, 32'h0, 32'h00000001, 1'b0);
    run_single({96'h0, 32'h00008000}, {96'h0, 32'hFFFFFFFF}, 32'h0, 32'h00000000, 1'b0);
`ifdef NEURON_MAC_RELU_EN
    run_single({96'h0, 32'h00008000}, {96'h0, 32'hFFFFFFFD}, 32'h0, 32'h00000000, 1'b0);
    run_single({96'h0, 32'h00010000}, {96'h0, 32'hFFFD0000}, 32'h0, 32'h00000000, 1'b0);
    run_single(rep(32'h80010000), rep(32'h7FFF0000), 32'h0, 32'h00000000, 1'b0);
`else
    run_single({96'h0, 32'h00008000}, {96'h0, 32'hFFFFFFFD}, 32'h0, 32'hFFFFFFFF, 1'b0);
    run_single({96'h0, 32'h00010000}, {96'h0, 32'hFFFD0000}, 32'h0, 32'hFFFD0000, 1'b0);
    run_single(rep(32'h80010000), rep(32'h7FFF0000), 32'h0, 32'h80000000, 1'b1);
`endif
    run_single(rep(32'h7FFF0000), rep(32'h7FFF0000), 32'h0, 32'h7FFFFFFF, 1'b1);

    // clr mid-vector with a beat offered: beat dropped, outputs and accumulator zeroed.
    send_beat(1, 0, rep(32'h00010000), rep(32'h00010000), 32'h00050000, 0);
    clr = 1'b1;
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
    input_data = rep(32'h00030000); weight_data = rep(32'h00030000); bias = 32'h00020000;
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    #1;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_out_data", out_data, 0);
    chk("clr_sat", sat, 0);
    chk("clr_in_ready", in_ready, 1);
    m_acc = '0;
    repeat (3) @(negedge clk);
    #1 chk("clr_beat_dropped", out_valid, 0);
    @(negedge clk);
    send_beat(0, 1, rep(32'h00010000), rep(32'h00030000), 32'h0, 1);
    wait_valid();
    chk("after_clr_data", out_data, 32'h000C0000);
    release_out();

    // Reset while holding a result, then mid-vector.
    send_beat(1, 1, rep(32'h00010000), rep(32'h00010000), 32'h0, 0);
    wait_valid();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", out_valid, 0);
    chk("rst_hold_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("rst_hold_in_ready", in_ready, 1);
    @(negedge clk);
    send_beat(1, 0, rep(32'h00040000), rep(32'h00040000), 32'h00070000, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = '0;
    @(negedge clk);
    send_beat(0, 1, rep(32'h00020000), rep(32'h00010000), 32'h0, 1);
    wait_valid();
    chk("after_rst_data", out_data, 32'h00080000);
    release_out();

    // Randomized vectors with random backpressure and occasional mid-vector restarts.
    bp_rand = 1'b1;
    for (int v = 0; v < 40; v++) begin
      nb = $urandom_range(1, 5);
      mode = ($urandom_range(0, 2) == 0);
      for (int j = 0; j < nb; j++) begin
        first = (j == 0) || ($urandom_range(0, 7) == 0);
        for (int k = 0; k < L; k++) begin
          din[k*32 +: 32] = mode ? $urandom() : small_val();
          win[k*32 +: 32] = mode ? $urandom() : small_val();
        end
        b = mode ? $urandom() : small_val();
        send_beat(first, (j == nb - 1), din, win, b, 1);
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    bp_rand = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
